// File: rtl/adder_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
// Sizes the step counter that walks the nibbles of the operands.
package adder_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter width for a nibble index; a single-nibble build still needs one bit
  function automatic int idx_width(input int nibbles);
    if (nibbles <= 1) begin
      return 1;
    end else begin
      return $clog2(nibbles);
    end
  endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Operand/result handshake bundle for adder_seq_ctrl. The op line exists
// only when ADDSEQ_SUB_EN is defined.
interface adder_seq_ctrl_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
`ifdef ADDSEQ_SUB_EN
  logic         op;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         busy;

  modport slave (
`ifdef ADDSEQ_SUB_EN
    input  op,
`endif
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, busy
  );

  modport master (
`ifdef ADDSEQ_SUB_EN
    output op,
`endif
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, busy
  );
endinterface

// File: rtl/adder_seq_ctrl_adder_4bit.sv
// Purely combinational 4-bit ripple-carry adder slice shared by the
// sequencer for every nibble pass.
module adder_4bit
  import adder_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               c_in,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);

  logic [SLICE_W:0] w_carry;

  assign w_carry[0] = c_in;

  // Each bit is one full adder feeding the next one up
  for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
    assign sum[gi]         = a[gi] ^ b[gi] ^ w_carry[gi];
    assign w_carry[gi + 1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
  end

  assign c_out = w_carry[SLICE_W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide adder built by reusing one 4-bit slice, least significant nibble
// first. Defining ADDSEQ_SUB_EN adds an op input selecting a-b.
module adder_seq_ctrl
  import adder_seq_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  adder_seq_ctrl_if.slave bus
);

  localparam int W     = SLICE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_e r_state;
  state_e w_next_state;

  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic [W-1:0]       r_sum;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
`ifdef ADDSEQ_SUB_EN
  logic               r_op;
`endif

  logic               w_accept;
  logic               w_last;
  logic [SLICE_W-1:0] w_a_nib;
  logic [SLICE_W-1:0] w_b_raw;
  logic [SLICE_W-1:0] w_b_nib;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_last   = (r_idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) begin
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Slice operand selection for the current nibble
  always_comb begin
    w_a_nib = r_a[r_idx * SLICE_W +: SLICE_W];
    w_b_raw = r_b[r_idx * SLICE_W +: SLICE_W];
`ifdef ADDSEQ_SUB_EN
    if (r_op) begin
      w_b_nib = ~w_b_raw;
    end else begin
      w_b_nib = w_b_raw;
    end
`else
    w_b_nib = w_b_raw;
`endif
  end

  adder_4bit u_slice (
    .a     (w_a_nib),
    .b     (w_b_nib),
    .c_in  (r_carry),
    .sum   (w_slice_sum),
    .c_out (w_slice_cout)
  );

  // Operand capture, carry chaining between passes and result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
`ifdef ADDSEQ_SUB_EN
      r_op    <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a     <= bus.a;
      r_b     <= bus.b;
      r_sum   <= '0;
      r_idx   <= '0;
`ifdef ADDSEQ_SUB_EN
      // Two's complement subtract: inverted b plus a forced carry of one
      r_op    <= bus.op;
      r_carry <= bus.op ? 1'b1 : bus.c_in;
`else
      r_carry <= bus.c_in;
`endif
    end else if (r_state == RUN) begin
      r_sum[r_idx * SLICE_W +: SLICE_W] <= w_slice_sum;
      r_carry <= w_slice_cout;
      r_idx   <= r_idx + IDX_W'(1);
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.sum       = r_sum;
  assign bus.c_out     = r_carry;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed-vector bench for adder_seq_ctrl: a 4-nibble instance for the
// main sequences and a 1-nibble instance for the single-pass corner.
module tb_adder_seq_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  adder_seq_ctrl_if #(.W(16)) bus  ();
  adder_seq_ctrl_if #(.W(4))  bus1 ();

  adder_seq_ctrl #(.NIBBLES(4)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  adder_seq_ctrl #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

`ifdef ADDSEQ_SUB_EN
  logic op_sel = 1'b0;
  assign bus.op  = op_sel;
  assign bus1.op = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge, then count cycles until out_valid
  task automatic start_op(input string tag, input logic [15:0] a_v, input logic [15:0] b_v,
                          input logic cin);
    int cnt;
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.a        = a_v;
    bus.b        = b_v;
    bus.c_in     = cin;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check({tag, " busy"}, 32'(bus.busy), 32'd1);
    cnt = 0;
    while (!bus.out_valid && cnt < 40) begin
      step();
      cnt++;
    end
    check({tag, " latency"}, 32'(cnt), 32'd4);
  endtask

  task automatic run_op(input string tag, input logic [15:0] a_v, input logic [15:0] b_v,
                        input logic cin, input logic [15:0] exp_sum, input logic exp_c);
    start_op(tag, a_v, b_v, cin);
    check({tag, " sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, " c_out"}, 32'(bus.c_out), 32'(exp_c));
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, " out_valid after handoff"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready after handoff"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.a          = 16'h0000;
    bus.b          = 16'h0000;
    bus.c_in       = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.out_ready = 1'b0;
    bus1.a         = 4'h0;
    bus1.b         = 4'h0;
    bus1.c_in      = 1'b0;
    step();
    step();
    rst = 1'b0;

    check("reset in_ready",  32'(bus.in_ready),  32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset busy",      32'(bus.busy),      32'd0);
    check("reset sum",       32'(bus.sum),       32'd0);
    check("reset c_out",     32'(bus.c_out),     32'd0);

    run_op("add1234", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    run_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("cin7fff", 16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0);
    run_op("top_carry", 16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);

    // Backpressure: result held while out_ready low, new operands ignored
    start_op("bp", 16'h0102, 16'h0304, 1'b0);
    bus.a        = 16'hAAAA;
    bus.b        = 16'h5555;
    bus.c_in     = 1'b1;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp sum stable",   32'(bus.sum),       32'h0406);
      check("bp c_out stable", 32'(bus.c_out),     32'd0);
      check("bp in_ready low", 32'(bus.in_ready),  32'd0);
      check("bp out_valid",    32'(bus.out_valid), 32'd1);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("bp in_ready after handoff", 32'(bus.in_ready), 32'd1);
    check("bp out_valid dropped",      32'(bus.out_valid), 32'd0);
    step();
    check("bp no queued op", 32'(bus.busy), 32'd0);

    // Reset two cycles into an operation
    bus.a        = 16'h1234;
    bus.b        = 16'h4321;
    bus.c_in     = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst busy",      32'(bus.busy),      32'd0);
    check("midrst sum",       32'(bus.sum),       32'd0);
    check("midrst in_ready",  32'(bus.in_ready),  32'd1);
    run_op("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);

`ifdef ADDSEQ_SUB_EN
    op_sel = 1'b1;
    run_op("sub5m7", 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0);
    run_op("sub9m3", 16'h0009, 16'h0003, 1'b0, 16'h0006, 1'b1);
    op_sel = 1'b0;
`endif

    // Single-nibble instance: result one cycle after acceptance
    check("n1 in_ready", 32'(bus1.in_ready), 32'd1);
    bus1.a        = 4'hF;
    bus1.b        = 4'h1;
    bus1.c_in     = 1'b0;
    bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    check("n1 out_valid early", 32'(bus1.out_valid), 32'd0);
    step();
    check("n1 out_valid", 32'(bus1.out_valid), 32'd1);
    check("n1 sum",       32'(bus1.sum),       32'h0);
    check("n1 c_out",     32'(bus1.c_out),     32'd1);
    bus1.out_ready = 1'b1;
    step();
    bus1.out_ready = 1'b0;
    check("n1 in_ready after handoff", 32'(bus1.in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_seq_ctrl.md
# adder_seq_ctrl

Multi-cycle sequencer that performs wide additions (4*NIBBLES bits) by time-sharing a single 4-bit ripple adder slice, one nibble per clock, least significant nibble first. The carry is held in a register between nibbles. Operands arrive and results leave through valid/ready handshakes. The block sits between an operand producer and a result consumer wherever a narrow adder is reused to save area.

## Interface
- NIBBLES, default 4: number of 4-bit passes; operand width W = 4*NIBBLES; legal range 1..16.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request.
- in_ready  out  1  block can accept operands (IDLE only).
- a  in  W  operand A.
- b  in  W  operand B.
- c_in  in  1  initial carry-in.
- op  in  1  0 = add, 1 = subtract (present only with ADDSEQ_SUB_EN).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- sum  out  W  result word.
- c_out  out  1  final carry-out of the most significant nibble.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, b (and op) into operand registers, set idx=0, load carry register with c_in, clear the sum register, go to RUN.
- RUN:
  - Slice inputs: a_reg[4*idx+:4], b_reg[4*idx+:4], carry register.
  - At each edge, write the slice sum into sum_reg[4*idx+:4], write the slice c_out into the carry register, then idx++.
  - When idx==NIBBLES-1 at the edge, go to DONE.
- DONE:
  - out_valid=1; sum=sum_reg; c_out=carry register.
  - Hold all outputs stable until out_ready=1, then go to IDLE.
- in_valid outside IDLE is ignored; operands are not queued.
- Operand registers are not modified between acceptance and DONE exit.
- Arithmetic is modulo 2^W. c_out is the true carry from bit W-1. No signed overflow flag.
- Subtraction is covered under Configuration.

## Timing
- Reset values (rst high at an edge): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, idx=0.
- Reset mid-RUN or mid-DONE aborts the operation with no partial result presented. in_ready=1 on the cycle after the reset edge.
- Latency: out_valid rises NIBBLES cycles after the acceptance edge. With NIBBLES=1, it rises 1 cycle after.
- Result handoff occurs on the edge where out_valid&&out_ready. in_ready returns high the following cycle.
- Throughput with out_ready held high: one operation every NIBBLES+2 cycles.
- in_ready, out_valid and busy are registered state decodes, with no combinational path from in_valid or out_ready.

## Configuration
- ADDSEQ_SUB_EN defined:
  - op port exists.
  - When op=1 is latched, b is inverted nibble-wise into the slice and the initial carry is forced to 1 (c_in is ignored). Result is a-b mod 2^W.
  - c_out=1 means no borrow; c_out=0 means borrow.
- ADDSEQ_SUB_EN undefined: no op port, addition only, no inversion logic.

## Structure
- Shared package adder_seq_pkg holds:
  - state enum (IDLE, RUN, DONE);
  - SLICE_W=4 constant;
  - an idx width function, clog2(NIBBLES) with a minimum of 1.
- Sub-module: one instance of the team's adder_4bit slice (ports a, b, c_in, sum, c_out). It is purely combinational.
- All sequencing, carry and sum registers live in adder_seq_ctrl.

## Test plan
- NIBBLES=4, a=0x1234, b=0x1111, c_in=0 -> sum=0x2345, c_out=0; out_valid exactly 4 cycles after acceptance.
- a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1; carry ripples across all four passes. Then a=0x7FFF, b=0x0000, c_in=1 -> sum=0x8000, c_out=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE.
  - Required: sum/c_out stable, in_ready=0, and a new in_valid with different operands is ignored.
  - After out_ready=1: handoff occurs and in_ready=1 on the next cycle.
- Reset mid-operation:
  - Assert rst 2 cycles after acceptance.
  - Required: on the next cycle out_valid=0, busy=0, sum=0, in_ready=1.
  - A fresh a=0x0001, b=0x0002 then yields 0x0003.
- With ADDSEQ_SUB_EN, op=1:
  - a=0x0005, b=0x0007 -> sum=0xFFFE, c_out=0.
  - a=0x0009, b=0x0003 -> sum=0x0006, c_out=1.
- NIBBLES=1, a=0xF, b=0x1 -> sum=0x0, c_out=1; out_valid 1 cycle after acceptance.
